// File: rtl/sys_ctrl_rf_sequencer_pkg.sv
// Shared definitions for the RX-to-register-file command sequencer:
// FSM state encoding and the default frame command bytes.
package sys_ctrl_rf_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_PUSH = 3'd5
  } seq_state_t;

  localparam logic [7:0] DEF_WR_CMD = 8'hAA;
  localparam logic [7:0] DEF_RD_CMD = 8'hBB;

endpackage

// File: rtl/sys_ctrl_rf_sequencer.sv
// Command sequencer: parses RX byte frames (write: cmd,addr,data / read: cmd,addr),
// issues one register-file access per frame and forwards read data to the TX FIFO.
// Every output is a register; strobes default low each cycle so they pulse once.
module sys_ctrl_rf_sequencer
  import sys_ctrl_rf_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD     = DEF_WR_CMD,
  parameter logic [DATA_WIDTH-1:0] RD_CMD     = DEF_RD_CMD,
  parameter int                    RD_TIMEOUT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_Data,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  FIFO_FULL,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Frame_Err
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(RD_TIMEOUT - 1);

  seq_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic          addr_ok;

  // An address byte is usable only if no bit above the register-file range is set.
  assign addr_ok = (RX_P_Data[DATA_WIDTH-1:ADDR_WIDTH] == '0);

  // Frame-parsing FSM with registered strobes, address/data latches and read timeout.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_Data <= '0;
      TX_D_VLD  <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_Data == WR_CMD) begin
              state <= WR_ADDR;
            end else if (RX_P_Data == RD_CMD) begin
              state <= RD_ADDR;
            end else begin
              Frame_Err <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_ok) begin
              Address <= RX_P_Data[ADDR_WIDTH-1:0];
              state   <= WR_DATA;
            end else begin
              Frame_Err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData <= RX_P_Data;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_ok) begin
              Address  <= RX_P_Data[ADDR_WIDTH-1:0];
              RdEn     <= 1'b1;
              wait_cnt <= '0;
              state    <= RD_WAIT;
            end else begin
              Frame_Err <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        RD_WAIT: begin
          if (RdData_Valid) begin
            TX_P_Data <= RdData;
            state     <= TX_PUSH;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            Frame_Err <= 1'b1;
            wait_cnt  <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        TX_PUSH: begin
          if (!FIFO_FULL) begin
            TX_D_VLD <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_rf_sequencer.sv
// Directed self-checking bench for sys_ctrl_rf_sequencer: write/read frames,
// FIFO back-pressure, bad command/address, read timeout and mid-frame reset.
module tb_sys_ctrl_rf_sequencer;

  localparam int RD_TIMEOUT = 4;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       FIFO_FULL;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       Frame_Err;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  int tx_pulses = 0;
  int err_pulses = 0;
  int both_high = 0;
  int wr_mark, rd_mark, tx_mark, err_mark;

  sys_ctrl_rf_sequencer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .WR_CMD(8'hAA),
    .RD_CMD(8'hBB),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_P_Data(RX_P_Data),
    .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .Address(Address),
    .WrData(WrData),
    .RdData(RdData),
    .RdData_Valid(RdData_Valid),
    .FIFO_FULL(FIFO_FULL),
    .TX_P_Data(TX_P_Data),
    .TX_D_VLD(TX_D_VLD),
    .Frame_Err(Frame_Err)
  );

  // 100 MHz-style free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse counters sample each strobe once per cycle.
  always @(posedge CLK) begin
    if (WrEn) wr_pulses++;
    if (RdEn) rd_pulses++;
    if (TX_D_VLD) tx_pulses++;
    if (Frame_Err) err_pulses++;
    if (WrEn && RdEn) both_high++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one RX byte for a single cycle; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic markCounts();
    wr_mark  = wr_pulses;
    rd_mark  = rd_pulses;
    tx_mark  = tx_pulses;
    err_mark = err_pulses;
  endtask

  initial begin
    RST = 1'b0;
    RX_P_Data = 8'h00;
    RX_D_VLD = 1'b0;
    RdData = 8'h00;
    RdData_Valid = 1'b0;
    FIFO_FULL = 1'b0;

    // Reset state
    #12;
    checkOutput("reset_WrEn", 32'(WrEn), 32'd0);
    checkOutput("reset_RdEn", 32'(RdEn), 32'd0);
    checkOutput("reset_Address", 32'(Address), 32'd0);
    checkOutput("reset_TX_D_VLD", 32'(TX_D_VLD), 32'd0);
    checkOutput("reset_Frame_Err", 32'(Frame_Err), 32'd0);
    #11 RST = 1'b1;
    tick();

    // Test 1: write frame AA,05,3C
    markCounts();
    applyStimulus(8'hAA);
    applyStimulus(8'h05);
    applyStimulus(8'h3C);
    checkOutput("t1_WrEn", 32'(WrEn), 32'd1);
    checkOutput("t1_Address", 32'(Address), 32'h5);
    checkOutput("t1_WrData", 32'(WrData), 32'h3C);
    checkOutput("t1_RdEn", 32'(RdEn), 32'd0);
    tick();
    checkOutput("t1_WrEn_drop", 32'(WrEn), 32'd0);
    checkOutput("t1_wr_count", 32'(wr_pulses - wr_mark), 32'd1);
    checkOutput("t1_rd_count", 32'(rd_pulses - rd_mark), 32'd0);

    // Test 2: read frame BB,05 with data returned the cycle after RdEn
    markCounts();
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    checkOutput("t2_RdEn", 32'(RdEn), 32'd1);
    checkOutput("t2_Address", 32'(Address), 32'h5);
    checkOutput("t2_WrEn", 32'(WrEn), 32'd0);
    tick();
    checkOutput("t2_RdEn_drop", 32'(RdEn), 32'd0);
    RdData = 8'h3C;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    checkOutput("t2_TX_P_Data", 32'(TX_P_Data), 32'h3C);
    checkOutput("t2_TX_D_VLD_early", 32'(TX_D_VLD), 32'd0);
    tick();
    checkOutput("t2_TX_D_VLD", 32'(TX_D_VLD), 32'd1);
    tick();
    checkOutput("t2_TX_D_VLD_drop", 32'(TX_D_VLD), 32'd0);
    checkOutput("t2_TX_P_Data_hold", 32'(TX_P_Data), 32'h3C);
    checkOutput("t2_tx_count", 32'(tx_pulses - tx_mark), 32'd1);
    checkOutput("t2_rd_count", 32'(rd_pulses - rd_mark), 32'd1);

    // Test 3: same read with the TX FIFO full for 6 cycles
    markCounts();
    FIFO_FULL = 1'b1;
    applyStimulus(8'hBB);
    applyStimulus(8'h05);
    tick();
    RdData = 8'hC3;
    RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    checkOutput("t3_TX_P_Data", 32'(TX_P_Data), 32'hC3);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("t3_TX_D_VLD_full", 32'(TX_D_VLD), 32'd0);
    end
    FIFO_FULL = 1'b0;
    tick();
    checkOutput("t3_TX_D_VLD", 32'(TX_D_VLD), 32'd1);
    checkOutput("t3_TX_P_Data_push", 32'(TX_P_Data), 32'hC3);
    tick();
    checkOutput("t3_TX_D_VLD_drop", 32'(TX_D_VLD), 32'd0);
    checkOutput("t3_tx_count", 32'(tx_pulses - tx_mark), 32'd1);

    // Test 4: bad command byte, then a normal write
    markCounts();
    applyStimulus(8'h11);
    checkOutput("t4_Frame_Err", 32'(Frame_Err), 32'd1);
    tick();
    checkOutput("t4_Frame_Err_drop", 32'(Frame_Err), 32'd0);
    applyStimulus(8'hAA);
    applyStimulus(8'h02);
    applyStimulus(8'h81);
    checkOutput("t4_WrEn", 32'(WrEn), 32'd1);
    checkOutput("t4_Address", 32'(Address), 32'h2);
    checkOutput("t4_WrData", 32'(WrData), 32'h81);
    checkOutput("t4_err_count", 32'(err_pulses - err_mark), 32'd1);

    // Test 5a: out-of-range write address
    tick();
    markCounts();
    applyStimulus(8'hAA);
    applyStimulus(8'h15);
    checkOutput("t5_addr_Frame_Err", 32'(Frame_Err), 32'd1);
    tick(); tick();
    checkOutput("t5_addr_wr_count", 32'(wr_pulses - wr_mark), 32'd0);

    // Test 5b: read with no RdData_Valid times out after RD_TIMEOUT cycles
    markCounts();
    applyStimulus(8'hBB);
    applyStimulus(8'h03);
    checkOutput("t5_RdEn", 32'(RdEn), 32'd1);
    for (int i = 1; i < RD_TIMEOUT; i++) begin
      tick();
      checkOutput("t5_no_early_timeout", 32'(Frame_Err), 32'd0);
    end
    tick();
    checkOutput("t5_timeout_Frame_Err", 32'(Frame_Err), 32'd1);
    tick();
    checkOutput("t5_timeout_drop", 32'(Frame_Err), 32'd0);
    checkOutput("t5_tx_count", 32'(tx_pulses - tx_mark), 32'd0);

    // Test 6: reset in the middle of a write frame
    markCounts();
    applyStimulus(8'hAA);
    applyStimulus(8'h07);
    checkOutput("t6_Address_before", 32'(Address), 32'h7);
    RST = 1'b0;
    #2;
    checkOutput("t6_rst_Address", 32'(Address), 32'd0);
    checkOutput("t6_rst_WrData", 32'(WrData), 32'd0);
    checkOutput("t6_rst_TX_P_Data", 32'(TX_P_Data), 32'd0);
    tick(); tick();
    #2 RST = 1'b1;
    applyStimulus(8'h55);
    checkOutput("t6_Frame_Err", 32'(Frame_Err), 32'd1);
    tick();
    checkOutput("t6_wr_count", 32'(wr_pulses - wr_mark), 32'd0);
    checkOutput("t6_rd_count", 32'(rd_pulses - rd_mark), 32'd0);

    // Global: write and read strobes never overlap
    checkOutput("never_both_high", 32'(both_high), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
